registers_common_mc: RTL and testbench
======================================

Name: registers_common_mc

Overview:
Parametrised, multi-channel successor to the common user register block. It sits behind the AXI-Lite IPIF slave on the same Bus2IP/IP2Bus interface. It adds N Ethernet channels (MAC ID, sticky PHY status, interrupt mask), a scratchpad array, byte enables, an error response for unmapped accesses, atomic 64-bit PCIe counter snapshots, and an aggregated level interrupt.

Parameters:
C_S_AXI_BASEADDR, 32'h0000_0000, base address; decode uses (Bus2IP_Addr - base)[11:0].
NUM_CHAN, 2, number of Ethernet channels (1..8).
SCRATCH_DEPTH, 4, number of 32-bit scratchpad words (1..16).
DESIGN_VER, 8'h20, value returned in VERSION[7:0].

Ports:
clk  in  1  register clock.
rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
Bus2IP_Addr  in  32  byte address.
Bus2IP_RNW  in  1  1 = read, 0 = write.
Bus2IP_CS  in  1  chip select; held until ack.
Bus2IP_BE  in  4  byte enables for writes.
Bus2IP_Data  in  32  write data.
IP2Bus_Data  out  32  read data.
IP2Bus_WrAck  out  1  write acknowledge, 1-cycle pulse.
IP2Bus_RdAck  out  1  read acknowledge, 1-cycle pulse.
IP2Bus_Error  out  1  asserted with the ack for unmapped accesses.
ddr4_calib_done  in  1  status input.
tx_pcie_bc  in  64  free-running TX byte count.
rx_pcie_bc  in  64  free-running RX byte count.
phy_status  in  8*NUM_CHAN  per-channel raw PHY status.
scaling_factor  out  2  RW control.
clk_period_reg  out  32  RW control.
mac_id  out  48*NUM_CHAN  per-channel MAC ID; channel n occupies bits [48n+47:48n].
irq  out  1  level interrupt.

Behaviour:
- Reset (async): outputs and ack/error = 0; scaling_factor = 2'b10; clk_period_reg = 32'h0EE6B280; all scratch words = 32'hDEADDEAF; mac_id[n] = 48'hAABBCCDDEE00 + n; sticky = 0; mask = 0; snapshots = 0; irq = 0.
- Handshake: FSM with states IDLE, ACK, WAIT.
  - IDLE: CS=1 → perform the access and go to ACK.
  - ACK: the ack and error outputs are registered and asserted for exactly 1 cycle; go to WAIT.
  - WAIT: remain until CS=0, then go to IDLE. This guarantees one ack per CS assertion.
  - Latency: CS sampled → ack at the next clock edge.
- Read data is valid only with RdAck and is 0 otherwise. WrAck and RdAck are never asserted together.
- Offset map:
  - 0x000 VERSION RO = {16'd0, NUM_CHAN[7:0], DESIGN_VER}.
  - 0x004 STATUS RO = {31'd0, ddr4_calib_done}.
  - 0x008 SCALE RW [1:0].
  - 0x014 CLK_PERIOD RW.
  - 0x040 + 4i SCRATCH[i] RW, for i < SCRATCH_DEPTH.
  - 0x100 TX_BC_LO RO: returns tx_pcie_bc[31:0] and, in the same cycle, latches tx_pcie_bc[63:32] into tx_shadow.
  - 0x104 TX_BC_HI RO: returns tx_shadow.
  - 0x108 and 0x10C: RX_BC_LO and RX_BC_HI, identical behaviour with rx_shadow.
  - 0x400 + 0x10n (channel n): +0 MAC_LO RW [31:0]; +4 MAC_HI RW [15:0], upper bits read 0; +8 PHY_STICKY RO/W1C [7:0]; +C IRQ_MASK RW [7:0].
- Byte enables: each RW register updates only the enabled bytes. Bytes beyond the field width are ignored. W1C acts only on enabled bytes.
- Unmapped accesses set Error=1 together with the normal ack; reads return 0 and writes have no effect. An access is unmapped if it is:
  - any undefined offset;
  - scratch index ≥ SCRATCH_DEPTH;
  - channel n ≥ NUM_CHAN;
  - a write to an RO register;
  - an offset ≥ 0x800.
- Sticky capture:
  - phy_status is registered once as phy_q.
  - Every cycle: sticky[n] |= phy_status[n] & ~phy_q[n] (rising-edge detect).
  - W1C clears the written 1-bits.
  - A new rising edge in the same cycle as a W1C on that bit leaves the bit set (set wins).
- irq is registered: irq = OR over n of |(sticky[n] & mask[n]), with 1-cycle latency from a sticky or mask change.
- Snapshot reads: HI reads without a prior LO read return the last latched value (0 after reset).
- Reset asserted mid-transaction: FSM returns to IDLE and no ack is issued. If CS is still high after reset release, the access is treated as new.

Test Plan:
1. Reset, then read 0x000, 0x008, 0x014, 0x040 → 0x00000220, 0x2, 0x0EE6B280, 0xDEADDEAF; each RdAck is 1 cycle with Error=0.
2. Write 0x12345678 to SCRATCH[1] with BE=4'b0101, then read it back → 0xDE34DE78. Hold CS for 5 cycles → exactly one WrAck.
3. With tx_pcie_bc = 0x00000001_FFFFFFF0: read 0x100 → 0xFFFFFFF0; counter then advances to 0x00000002_00000010; read 0x104 → 0x00000001.
4. Write 0x400+0x20 with NUM_CHAN=2 → WrAck with Error=1, no state change. Read 0x060 with SCRATCH_DEPTH=4 → data 0, Error=1.
5. Pulse phy_status[9] (ch1 bit1) 0→1→0 with mask ch1 = 0x02 → sticky 0x02 and irq=1 one cycle later. Write 0x02 to 0x418 → sticky 0 and irq=0. Repeat with an edge coincident with the W1C → sticky stays 0x02.
6. Assert rst_n=0 during an ACK cycle → ack drops immediately; all registers return to reset values; mac_id ch1 = 0xAABBCCDDEE01.

Source files
------------

// File: rtl/registers_common_mc_if.sv
// Bus2IP/IP2Bus register-access bundle between the AXI-Lite IPIF and the register block.
interface registers_common_mc_if;
  logic [31:0] Bus2IP_Addr;
  logic        Bus2IP_RNW;
  logic        Bus2IP_CS;
  logic [3:0]  Bus2IP_BE;
  logic [31:0] Bus2IP_Data;
  logic [31:0] IP2Bus_Data;
  logic        IP2Bus_WrAck;
  logic        IP2Bus_RdAck;
  logic        IP2Bus_Error;

  modport master (
    output Bus2IP_Addr, Bus2IP_RNW, Bus2IP_CS, Bus2IP_BE, Bus2IP_Data,
    input  IP2Bus_Data, IP2Bus_WrAck, IP2Bus_RdAck, IP2Bus_Error
  );

  modport slave (
    input  Bus2IP_Addr, Bus2IP_RNW, Bus2IP_CS, Bus2IP_BE, Bus2IP_Data,
    output IP2Bus_Data, IP2Bus_WrAck, IP2Bus_RdAck, IP2Bus_Error
  );
endinterface

// File: rtl/registers_common_mc.sv
// Multi-channel common register block: config, scratchpad, PCIe counter snapshots,
// per-channel MAC ID / sticky PHY status / interrupt mask, aggregated level irq.
//
// state  | meaning
// S_IDLE | waiting for CS; the access is performed on the edge that samples it
// S_ACK  | ack/error/read data presented for exactly one cycle
// S_WAIT | access done, waiting for CS to drop before accepting another
module registers_common_mc #(
  parameter logic [31:0] C_S_AXI_BASEADDR = 32'h0000_0000,
  parameter int          NUM_CHAN         = 2,
  parameter int          SCRATCH_DEPTH    = 4,
  parameter logic [7:0]  DESIGN_VER       = 8'h20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  registers_common_mc_if.slave     bus,
  input  logic                     ddr4_calib_done,
  input  logic [63:0]              tx_pcie_bc,
  input  logic [63:0]              rx_pcie_bc,
  input  logic [8*NUM_CHAN-1:0]    phy_status,
  output logic [1:0]               scaling_factor,
  output logic [31:0]              clk_period_reg,
  output logic [48*NUM_CHAN-1:0]   mac_id,
  output logic                     irq
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

  state_t state, state_nxt;
  logic   access;

  logic [31:0] addr_rel;
  logic [11:0] off;
  logic        unused_addr_bits;
  logic        hit, ro, err_c, wr_en, rd_en;
  logic [31:0] rd_val;

  logic [SCRATCH_DEPTH-1:0] scr_sel;
  logic [NUM_CHAN-1:0]      ch_sel;

  logic [1:0]  scale;
  logic [31:0] clk_period;
  logic [31:0] scratch [SCRATCH_DEPTH];
  logic [31:0] mac_lo  [NUM_CHAN];
  logic [15:0] mac_hi  [NUM_CHAN];
  logic [7:0]  sticky  [NUM_CHAN];
  logic [7:0]  mask    [NUM_CHAN];
  logic [7:0]  rise    [NUM_CHAN];
  logic [7:0]  clr     [NUM_CHAN];
  logic [8*NUM_CHAN-1:0] phy_q;
  logic [31:0] tx_shadow, rx_shadow;
  logic        irq_nxt;

  logic [31:0] rdata_q;
  logic        wr_ack_q, rd_ack_q, err_q;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    access    = 1'b0;
    case (state)
      S_IDLE: if (bus.Bus2IP_CS) begin
        access    = 1'b1;
        state_nxt = S_ACK;
      end
      S_ACK:  state_nxt = S_WAIT;
      S_WAIT: if (!bus.Bus2IP_CS) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign addr_rel         = bus.Bus2IP_Addr - C_S_AXI_BASEADDR;
  assign off              = addr_rel[11:0];
  assign unused_addr_bits = ^addr_rel[31:12];

  // Address decode; W1C sticky registers count as writable, not RO.
  always_comb begin
    hit     = 1'b0;
    ro      = 1'b0;
    rd_val  = '0;
    scr_sel = '0;
    ch_sel  = '0;
    if (off[1:0] == 2'b00 && !off[11]) begin
      case (off)
        12'h000: begin hit = 1'b1; ro = 1'b1; rd_val = {16'd0, 8'(NUM_CHAN), DESIGN_VER}; end
        12'h004: begin hit = 1'b1; ro = 1'b1; rd_val = {31'd0, ddr4_calib_done}; end
        12'h008: begin hit = 1'b1; rd_val = {30'd0, scale}; end
        12'h014: begin hit = 1'b1; rd_val = clk_period; end
        12'h100: begin hit = 1'b1; ro = 1'b1; rd_val = tx_pcie_bc[31:0]; end
        12'h104: begin hit = 1'b1; ro = 1'b1; rd_val = tx_shadow; end
        12'h108: begin hit = 1'b1; ro = 1'b1; rd_val = rx_pcie_bc[31:0]; end
        12'h10C: begin hit = 1'b1; ro = 1'b1; rd_val = rx_shadow; end
        default: ;
      endcase
      if (off[11:6] == 6'b000001) begin
        for (int i = 0; i < SCRATCH_DEPTH; i++) begin
          if (off[5:2] == 4'(i)) begin
            hit        = 1'b1;
            scr_sel[i] = 1'b1;
            rd_val     = scratch[i];
          end
        end
      end
      if (off[11:7] == 5'b01000) begin
        for (int n = 0; n < NUM_CHAN; n++) begin
          if (off[6:4] == 3'(n)) begin
            hit       = 1'b1;
            ch_sel[n] = 1'b1;
            case (off[3:2])
              2'd0:    rd_val = mac_lo[n];
              2'd1:    rd_val = {16'd0, mac_hi[n]};
              2'd2:    rd_val = {24'd0, sticky[n]};
              default: rd_val = {24'd0, mask[n]};
            endcase
          end
        end
      end
    end
  end

  assign err_c = !hit || (ro && !bus.Bus2IP_RNW);
  assign wr_en = access && !bus.Bus2IP_RNW && !err_c;
  assign rd_en = access &&  bus.Bus2IP_RNW && !err_c;

  always_comb begin
    irq_nxt = 1'b0;
    for (int n = 0; n < NUM_CHAN; n++) begin
      rise[n] = phy_status[8*n +: 8] & ~phy_q[8*n +: 8];
      clr[n]  = (wr_en && ch_sel[n] && off[3:2] == 2'd2 && bus.Bus2IP_BE[0])
                ? bus.Bus2IP_Data[7:0] : 8'd0;
      irq_nxt = irq_nxt | (|(sticky[n] & mask[n]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ack_q <= access && !bus.Bus2IP_RNW;
      rd_ack_q <= access &&  bus.Bus2IP_RNW;
      err_q    <= access && err_c;
      rdata_q  <= rd_en ? rd_val : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scale      <= 2'b10;
      clk_period <= 32'h0EE6_B280;
      tx_shadow  <= '0;
      rx_shadow  <= '0;
      phy_q      <= '0;
      irq        <= 1'b0;
      for (int i = 0; i < SCRATCH_DEPTH; i++) scratch[i] <= 32'hDEAD_DEAF;
      for (int n = 0; n < NUM_CHAN; n++) begin
        mac_lo[n] <= 32'hCCDD_EE00 + 32'(n);
        mac_hi[n] <= 16'hAABB;
        sticky[n] <= '0;
        mask[n]   <= '0;
      end
    end else begin
      phy_q <= phy_status;
      irq   <= irq_nxt;
      // Set wins over a coincident W1C on the same bit.
      for (int n = 0; n < NUM_CHAN; n++) sticky[n] <= (sticky[n] & ~clr[n]) | rise[n];
      if (rd_en && off == 12'h100) tx_shadow <= tx_pcie_bc[63:32];
      if (rd_en && off == 12'h108) rx_shadow <= rx_pcie_bc[63:32];
      if (wr_en) begin
        if (off == 12'h008) scale      <= 2'(be_merge({30'd0, scale}, bus.Bus2IP_Data, bus.Bus2IP_BE));
        if (off == 12'h014) clk_period <= be_merge(clk_period, bus.Bus2IP_Data, bus.Bus2IP_BE);
        for (int i = 0; i < SCRATCH_DEPTH; i++)
          if (scr_sel[i]) scratch[i] <= be_merge(scratch[i], bus.Bus2IP_Data, bus.Bus2IP_BE);
        for (int n = 0; n < NUM_CHAN; n++) begin
          if (ch_sel[n]) begin
            case (off[3:2])
              2'd0:    mac_lo[n] <= be_merge(mac_lo[n], bus.Bus2IP_Data, bus.Bus2IP_BE);
              2'd1:    mac_hi[n] <= 16'(be_merge({16'd0, mac_hi[n]}, bus.Bus2IP_Data, bus.Bus2IP_BE));
              2'd3:    mask[n]   <= 8'(be_merge({24'd0, mask[n]}, bus.Bus2IP_Data, bus.Bus2IP_BE));
              default: ;
            endcase
          end
        end
      end
    end
  end

  for (genvar n = 0; n < NUM_CHAN; n++) begin : g_mac
    assign mac_id[48*n +: 48] = {mac_hi[n], mac_lo[n]};
  end

  assign scaling_factor   = scale;
  assign clk_period_reg   = clk_period;
  assign bus.IP2Bus_Data  = rdata_q;
  assign bus.IP2Bus_WrAck = wr_ack_q;
  assign bus.IP2Bus_RdAck = rd_ack_q;
  assign bus.IP2Bus_Error = err_q;

endmodule

// File: tb/tb_registers_common_mc.sv
// Directed bench for registers_common_mc: hand-computed register map, byte-enable,
// snapshot, error, sticky/irq and mid-transaction reset checks.
module tb_registers_common_mc;
  localparam int NCH = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ddr4_calib_done;
  logic [63:0]       tx_pcie_bc, rx_pcie_bc;
  logic [8*NCH-1:0]  phy_status;
  logic [1:0]        scaling_factor;
  logic [31:0]       clk_period_reg;
  logic [48*NCH-1:0] mac_id;
  logic              irq;

  int n_cmp = 0;
  int n_mis = 0;
  int overlap_cnt = 0;
  int leak_cnt = 0;

  registers_common_mc_if bus ();

  registers_common_mc #(
    .C_S_AXI_BASEADDR(32'h0000_0000),
    .NUM_CHAN(NCH),
    .SCRATCH_DEPTH(4),
    .DESIGN_VER(8'h20)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .ddr4_calib_done(ddr4_calib_done),
    .tx_pcie_bc(tx_pcie_bc),
    .rx_pcie_bc(rx_pcie_bc),
    .phy_status(phy_status),
    .scaling_factor(scaling_factor),
    .clk_period_reg(clk_period_reg),
    .mac_id(mac_id),
    .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.IP2Bus_WrAck && bus.IP2Bus_RdAck) overlap_cnt++;
    if (!bus.IP2Bus_RdAck && bus.IP2Bus_Data != 32'd0) leak_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_start(input logic rnw, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata);
    bus.Bus2IP_RNW  = rnw;
    bus.Bus2IP_Addr = addr;
    bus.Bus2IP_BE   = be;
    bus.Bus2IP_Data = wdata;
    bus.Bus2IP_CS   = 1'b1;
  endtask

  // Hold CS for 'hold' cycles, counting acks; bounded by construction.
  task automatic bus_finish(input logic rnw, input int hold,
                            output logic [31:0] rdata, output logic err, output int acks);
    rdata = '0;
    err   = 1'b0;
    acks  = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rnw ? bus.IP2Bus_RdAck : bus.IP2Bus_WrAck) begin
        acks++;
        rdata = bus.IP2Bus_Data;
        err   = bus.IP2Bus_Error;
      end
    end
    bus.Bus2IP_CS = 1'b0;
  endtask

  task automatic do_wr(input string tag, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input logic exp_err, input int hold);
    logic [31:0] rd;
    logic        err;
    int          acks;
    @(negedge clk);
    bus_start(1'b0, addr, be, wdata);
    bus_finish(1'b0, hold, rd, err, acks);
    chk({tag, "_ack"}, 64'(acks), 64'd1);
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
  endtask

  task automatic do_rd(input string tag, input logic [31:0] addr,
                       input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    int          acks;
    @(negedge clk);
    bus_start(1'b1, addr, 4'hF, 32'd0);
    bus_finish(1'b1, 2, rd, err, acks);
    chk({tag, "_ack"},  64'(acks), 64'd1);
    chk({tag, "_data"}, 64'(rd), 64'(exp_data));
    chk({tag, "_err"},  64'(err), 64'(exp_err));
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          acks;

    rst_n           = 1'b0;
    bus.Bus2IP_CS   = 1'b0;
    bus.Bus2IP_RNW  = 1'b1;
    bus.Bus2IP_Addr = '0;
    bus.Bus2IP_BE   = '0;
    bus.Bus2IP_Data = '0;
    ddr4_calib_done = 1'b1;
    tx_pcie_bc      = '0;
    rx_pcie_bc      = '0;
    phy_status      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // reset state
    chk("rst_scale", 64'(scaling_factor), 64'h2);
    chk("rst_clkp", 64'(clk_period_reg), 64'h0EE6B280);
    chk("rst_mac0", 64'(mac_id[47:0]), 64'hAABBCCDDEE00);
    chk("rst_mac1", 64'(mac_id[95:48]), 64'hAABBCCDDEE01);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_wrack", 64'(bus.IP2Bus_WrAck), 64'd0);

    do_rd("version", 32'h000, 32'h0000_0220, 1'b0);
    do_rd("scale", 32'h008, 32'h2, 1'b0);
    do_rd("clkp", 32'h014, 32'h0EE6B280, 1'b0);
    do_rd("scr0", 32'h040, 32'hDEADDEAF, 1'b0);
    do_rd("status", 32'h004, 32'h1, 1'b0);

    // byte enables, long CS hold gives a single ack
    do_wr("scr1_wr", 32'h044, 4'b0101, 32'h12345678, 1'b0, 5);
    do_rd("scr1_rd", 32'h044, 32'hDE34DE78, 1'b0);
    do_wr("scale_be0", 32'h008, 4'b0000, 32'h1, 1'b0, 2);
    chk("scale_be0_val", 64'(scaling_factor), 64'h2);
    do_wr("scale_wr", 32'h008, 4'b0001, 32'hFFFF_FFF1, 1'b0, 2);
    chk("scale_val", 64'(scaling_factor), 64'h1);
    do_wr("maclo1", 32'h410, 4'hF, 32'h11223344, 1'b0, 2);
    do_wr("machi1", 32'h414, 4'hF, 32'hFFFF5566, 1'b0, 2);
    do_rd("machi1_rd", 32'h414, 32'h0000_5566, 1'b0);
    chk("mac1_out", 64'(mac_id[95:48]), 64'h556611223344);

    // snapshots
    do_rd("rxhi_rst", 32'h10C, 32'h0, 1'b0);
    tx_pcie_bc = 64'h0000_0001_FFFF_FFF0;
    do_rd("txlo", 32'h100, 32'hFFFFFFF0, 1'b0);
    tx_pcie_bc = 64'h0000_0002_0000_0010;
    do_rd("txhi", 32'h104, 32'h0000_0001, 1'b0);
    rx_pcie_bc = 64'h0000_ABCD_0000_1234;
    do_rd("rxlo", 32'h108, 32'h0000_1234, 1'b0);
    rx_pcie_bc = 64'h0000_9999_0000_0000;
    do_rd("rxhi", 32'h10C, 32'h0000_ABCD, 1'b0);

    // unmapped accesses
    do_wr("ch2_wr", 32'h420, 4'hF, 32'h0, 1'b1, 2);
    chk("ch2_mac0", 64'(mac_id[47:0]), 64'hAABBCCDDEE00);
    chk("ch2_mac1", 64'(mac_id[95:48]), 64'h556611223344);
    do_rd("scr4_rd", 32'h060, 32'h0, 1'b1);
    do_wr("ro_wr", 32'h000, 4'hF, 32'hFFFFFFFF, 1'b1, 2);
    do_rd("undef_rd", 32'h00C, 32'h0, 1'b1);
    do_rd("hi_rd", 32'h800, 32'h0, 1'b1);
    do_rd("version2", 32'h000, 32'h0000_0220, 1'b0);

    // sticky capture and irq
    do_wr("mask1", 32'h41C, 4'b0001, 32'h02, 1'b0, 2);
    @(negedge clk);
    phy_status[9] = 1'b1;
    @(negedge clk);
    chk("irq_lat", 64'(irq), 64'd0);
    phy_status[9] = 1'b0;
    @(negedge clk);
    chk("irq_set", 64'(irq), 64'd1);
    do_rd("sticky1", 32'h418, 32'h02, 1'b0);
    do_wr("w1c", 32'h418, 4'b0001, 32'h02, 1'b0, 2);
    do_rd("sticky1_clr", 32'h418, 32'h00, 1'b0);
    chk("irq_clr", 64'(irq), 64'd0);

    @(negedge clk);
    phy_status[9] = 1'b1;
    @(negedge clk);
    phy_status[9] = 1'b0;
    @(negedge clk);
    phy_status[9] = 1'b1;
    bus_start(1'b0, 32'h418, 4'b0001, 32'h02);
    bus_finish(1'b0, 2, rd, err, acks);
    chk("w1c_coinc_ack", 64'(acks), 64'd1);
    phy_status[9] = 1'b0;
    do_rd("sticky_coinc", 32'h418, 32'h02, 1'b0);
    do_wr("w1c_be0", 32'h418, 4'b0000, 32'h02, 1'b0, 2);
    do_rd("sticky_be0", 32'h418, 32'h02, 1'b0);
    chk("irq_coinc", 64'(irq), 64'd1);
    do_rd("sticky0", 32'h408, 32'h00, 1'b0);

    // reset during the ack cycle
    @(negedge clk);
    bus_start(1'b0, 32'h040, 4'hF, 32'hA5A5A5A5);
    @(posedge clk);
    #1;
    chk("mid_ack", 64'(bus.IP2Bus_WrAck), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_ack_drop", 64'(bus.IP2Bus_WrAck), 64'd0);
    chk("mid_scale", 64'(scaling_factor), 64'h2);
    chk("mid_mac1", 64'(mac_id[95:48]), 64'hAABBCCDDEE01);
    chk("mid_irq", 64'(irq), 64'd0);
    @(negedge clk);
    bus.Bus2IP_Data = 32'h12345678;
    @(negedge clk);
    rst_n = 1'b1;
    bus_finish(1'b0, 3, rd, err, acks);
    chk("post_rst_ack", 64'(acks), 64'd1);
    do_rd("post_rst_scr0", 32'h040, 32'h12345678, 1'b0);
    do_rd("post_rst_sticky", 32'h418, 32'h0, 1'b0);
    do_rd("post_rst_txhi", 32'h104, 32'h0, 1'b0);
    do_rd("post_rst_scr1", 32'h044, 32'hDEADDEAF, 1'b0);

    chk("ack_overlap", 64'(overlap_cnt), 64'd0);
    chk("rdata_leak", 64'(leak_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
